seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. Runs entirely on the single system clock `clk` and generates its own per-digit slot timing and blink phase from internal terminal-count counters, with no derived clocks. Each frame it captures a consistent snapshot of the display data, drives one digit per slot with an anti-ghosting blank interval, and optionally blinks selected digits. It sits between the lab's data path (hex values, enables) and the board anode/segment pins.

---
 rtl/seg_scan_controller.sv | 165 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Eight-digit common-anode seven-segment scan controller with per-frame input snapshot and guard blanking.
// Optional digit blinking is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_controller #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLINK_HZ  = 2,
  parameter int GUARD_CYC = 16,
  parameter int N_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_LAST = SLOT_W'(GUARD_CYC - 1);
  localparam logic [2:0]        IDX_LAST   = 3'(N_DIGITS - 1);

  typedef enum logic {GUARD = 1'b0, DRIVE = 1'b1} state_e;
  // With no guard interval a slot opens straight into DRIVE.
  localparam state_e SLOT_START = (GUARD_CYC == 0) ? DRIVE : GUARD;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  state_e            state_q;
  logic [SLOT_W-1:0] slot_cnt_q;
  logic [2:0]        idx_q;
  logic [31:0]       snap_data_q;
  logic [7:0]        snap_en_q;
  logic [7:0]        snap_dp_q;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              boundary_s;
  logic              slot_wrap_s;
  logic              blink_off_s;
  logic              lit_s;

  assign boundary_s  = (slot_cnt_q == '0) && (idx_q == 3'd0);
  assign slot_wrap_s = (slot_cnt_q == SLOT_LAST);
  assign frame_start = boundary_s & ~rst;

`ifdef SEG_SCAN_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic [7:0]         snap_blink_q;

  // Free-running blink half-period counter; deliberately not frame-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_blink_q  <= 8'h00;
    end else begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
      if (boundary_s) begin
        snap_blink_q <= blink_mask;
      end
    end
  end

  assign blink_off_s = snap_blink_q[idx_q] & blink_phase_q;
`else
  logic unused_s;
  assign unused_s    = ^{blink_mask, BLINK_HZ[0]};
  assign blink_off_s = 1'b0;
`endif

  assign lit_s = (state_q == DRIVE) & snap_en_q[idx_q] & ~blink_off_s;

  // Next pin values from this cycle's slot state; they reach the pins one cycle later.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit_s) begin
      an_d  = ~(8'h01 << idx_q);
      seg_d = hex_to_seg(snap_data_q[{idx_q, 2'b00} +: 4]);
      dp_d  = ~snap_dp_q[idx_q];
    end else begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // Slot FSM, digit index, frame snapshot and registered pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SLOT_START;
      slot_cnt_q  <= '0;
      idx_q       <= 3'd0;
      snap_data_q <= 32'h0;
      snap_en_q   <= 8'h00;
      snap_dp_q   <= 8'h00;
      an_q        <= 8'hFF;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      if (slot_wrap_s) begin
        slot_cnt_q <= '0;
        idx_q      <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        state_q    <= SLOT_START;
      end else begin
        slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
        case (state_q)
          GUARD:   state_q <= (slot_cnt_q == GUARD_LAST) ? DRIVE : GUARD;
          DRIVE:   state_q <= DRIVE;
          default: state_q <= GUARD;
        endcase
      end
      if (boundary_s) begin
        snap_data_q <= data_in;
        snap_en_q   <= digit_en;
        snap_dp_q   <= dp_mask;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: expected pins are pushed one cycle ahead of the DUT output.
module tb_seg_scan_controller;

  localparam int SCAN_DIV  = 10;
  localparam int BLINK_DIV = 20;
  localparam int GUARD     = 2;
  localparam int NDIG      = 8;
  localparam int FRAME     = SCAN_DIV * NDIG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  digit_en = 8'h00;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic [31:0] sd[0:3];
  logic [7:0]  se[0:3];
  logic [7:0]  sp[0:3];
  logic [7:0]  sb[0:3];

  seg_scan_controller #(
    .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(25), .GUARD_CYC(2), .N_DIGITS(8)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .digit_en(digit_en),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .an(an), .seg(seg),
    .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Expected pins for cycle c+1, derived from the cycle count c since reset release.
  task automatic model_push(input int c);
    int f, slot, d;
    logic ph, lit;
    logic [3:0] nib;
    f = (c / FRAME) % 4;
    slot = c % SCAN_DIV;
    d = (c / SCAN_DIV) % NDIG;
    if (c % FRAME == 0) begin
      sd[f] = data_in; se[f] = digit_en; sp[f] = dp_mask; sb[f] = blink_mask;
    end
`ifdef SEG_SCAN_BLINK_EN
    ph = ((c / BLINK_DIV) % 2) == 1;
`else
    ph = 1'b0;
`endif
    lit = (slot >= GUARD) && se[f][d] && !(sb[f][d] && ph);
    nib = sd[f][4*d +: 4];
    if (lit) exp_q.push_back({~(8'h01 << d), hex7(nib), ~sp[f][d]});
    else     exp_q.push_back({8'hFF, 7'h7F, 1'b1});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_q.push_back({8'hFF, 7'h7F, 1'b1});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_in = 32'h76543210; digit_en = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
  endtask

  task automatic test_scan();
    int lit0;
    data_in = 32'h76543210; digit_en = 8'hFF; dp_mask = 8'h00; blink_mask = 8'h00;
    do_reset();
    lit0 = 0;
    for (int c = 0; c < 170; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL scan_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      total++; if (frame_start !== (c % FRAME == 0)) begin bad++; $display("FAIL scan_fs c=%0d got=%b", c, frame_start); end
      if (c >= 1 && c <= 10 && an === 8'hFE) lit0++;
      if (c == 3) begin
        total++; if ({an, seg} !== {8'hFE, 7'h40}) begin bad++; $display("FAIL scan_digit0 got=%h/%h exp=fe/40", an, seg); end
      end
      if (c == 73) begin
        total++; if ({an, seg} !== {8'h7F, 7'h78}) begin bad++; $display("FAIL scan_digit7 got=%h/%h exp=7f/78", an, seg); end
      end
      model_push(c);
      @(negedge clk); #1;
    end
    total++; if (lit0 !== 8) begin bad++; $display("FAIL scan_lit_len got=%0d exp=8", lit0); end
  endtask

  task automatic test_freeze();
    data_in = 32'h76543210; digit_en = 8'hFF; dp_mask = 8'h00; blink_mask = 8'h00;
    do_reset();
    for (int c = 0; c < 170; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL freeze_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      if (c == 53) begin
        total++; if (seg !== 7'h12) begin bad++; $display("FAIL freeze_old got=%h exp=12", seg); end
      end
      if (c == 93) begin
        total++; if (seg !== 7'h0E) begin bad++; $display("FAIL freeze_new got=%h exp=0e", seg); end
      end
      if (c == 35) data_in = 32'hFFFFFFFF;
      model_push(c);
      @(negedge clk); #1;
    end
  endtask

  task automatic test_enable();
    data_in = 32'h89ABCDEF; digit_en = 8'b0000_0101; dp_mask = 8'h00; blink_mask = 8'h00;
    do_reset();
    for (int c = 0; c < 90; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL enable_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      total++; if (!(an === 8'hFF || an === 8'hFE || an === 8'hFB)) begin bad++; $display("FAIL enable_an c=%0d got=%h", c, an); end
      model_push(c);
      @(negedge clk); #1;
    end
  endtask

  task automatic test_blink();
    data_in = 32'h13572468; digit_en = 8'hFF; dp_mask = 8'h00; blink_mask = 8'h55;
    do_reset();
    for (int c = 0; c < 170; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL blink_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      if (c == 5) begin
        total++; if (an !== 8'hFE) begin bad++; $display("FAIL blink_d0 got=%h exp=fe", an); end
      end
      if (c == 25) begin
`ifdef SEG_SCAN_BLINK_EN
        total++; if (an !== 8'hFF) begin bad++; $display("FAIL blink_d2 got=%h exp=ff", an); end
`else
        total++; if (an !== 8'hFB) begin bad++; $display("FAIL blink_d2 got=%h exp=fb", an); end
`endif
      end
      model_push(c);
      @(negedge clk); #1;
    end
  endtask

  task automatic test_dp();
    data_in = 32'hFEDCBA98; digit_en = 8'hFF; dp_mask = 8'h80; blink_mask = 8'h00;
    do_reset();
    for (int c = 0; c < 90; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL dp_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      total++; if ((dp === 1'b0) !== (an === 8'h7F)) begin bad++; $display("FAIL dp_only7 c=%0d got an=%h dp=%b", c, an, dp); end
      model_push(c);
      @(negedge clk); #1;
    end
  endtask

  task automatic test_mid_reset();
    data_in = 32'h76543210; digit_en = 8'hFF; dp_mask = 8'h00; blink_mask = 8'h00;
    do_reset();
    for (int c = 0; c <= 43; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL midrst_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      if (c < 43) begin
        model_push(c);
        @(negedge clk); #1;
      end
    end
    total++; if (an !== 8'hEF) begin bad++; $display("FAIL midrst_lit got=%h exp=ef", an); end
    #2 rst = 1'b1;
    #1;
    total++; if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin bad++; $display("FAIL midrst_blank got=%h/%h/%b exp=ff/7f/1", an, seg, dp); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      e = exp_q.pop_front();
      total++; if ({an, seg, dp} !== e) begin bad++; $display("FAIL postrst_pins c=%0d got=%h/%h/%b exp=%h/%h/%b", c, an, seg, dp, e[15:8], e[7:1], e[0]); end
      total++; if (frame_start !== (c == 0)) begin bad++; $display("FAIL postrst_fs c=%0d got=%b", c, frame_start); end
      model_push(c);
      @(negedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_freeze();
    test_enable();
    test_blink();
    test_dp();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
